// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boot_pkg
//  Description : Shared types, constants and helpers for the instruction-
//                memory boot loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package boot_pkg;

  // Loader sequencing states: two header bytes, payload, checksum, terminals.
  typedef enum logic [2:0] {
    HDR0    = 3'd0,
    HDR1    = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } boot_state_t;

  // Bytes per instruction word.
  localparam int WORD_BYTES = 4;

  // Word index to byte address; the two low address bits are always zero.
  function automatic logic [31:0] word_to_addr(input logic [29:0] count);
    return {count, 2'b00};
  endfunction

endpackage : boot_pkg
`default_nettype wire

// File: rtl/boot_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : boot_word_assembler
//  Description : Packs a little-endian byte stream into 32-bit words and keeps
//                a running XOR checksum. Completed words are moved into a
//                separate output register so the partial buffer can accept the
//                next byte in the same cycle the word is being written.
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [1:0]  lane,
  output logic [7:0]  checksum,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] c_LAST_LANE = 2'(WORD_BYTES - 1);

  logic [1:0]  r_lane;
  logic [23:0] r_partial;
  logic [7:0]  r_checksum;
  logic [31:0] r_word;
  logic        r_word_valid;

  // Lane counter and running checksum advance on every accepted payload byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane     <= 2'd0;
      r_checksum <= 8'd0;
    end else if (in_valid) begin
      r_lane     <= r_lane + 2'd1;
      r_checksum <= r_checksum ^ in_data;
    end
  end

  // Lower three lanes collect in the partial buffer; the fourth byte completes
  // the word into the output register and raises a one-cycle valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_partial    <= 24'd0;
      r_word       <= 32'd0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (in_valid) begin
        case (r_lane)
          2'd0: r_partial[7:0]   <= in_data;
          2'd1: r_partial[15:8]  <= in_data;
          2'd2: r_partial[23:16] <= in_data;
          default: begin
            r_word       <= {in_data, r_partial};
            r_word_valid <= (r_lane == c_LAST_LANE);
          end
        endcase
      end
    end
  end

  assign lane       = r_lane;
  assign checksum   = r_checksum;
  assign word       = r_word;
  assign word_valid = r_word_valid;

endmodule : boot_word_assembler
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_loader
//  Description : Receives a length-prefixed, XOR-checksummed image over a byte
//                stream, writes it into instruction memory one word at a time
//                and releases the core from reset once the image verifies.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [31:0]      imem_waddr,
  output logic [31:0]      imem_wdata,
  output logic             core_rst,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH_WORDS);

  boot_state_t      r_state;
  boot_state_t      w_state_next;
  logic [7:0]       r_len_lo;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_word_count;
  logic [31:0]      r_waddr;
  logic             r_core_rst;

  logic             w_ready;
  logic             w_xfer;
  logic             w_payload_xfer;
  logic             w_word_end;
  logic             w_last_word;
  logic [CNT_W-1:0] w_len_full;
  logic [1:0]       w_lane;
  logic [7:0]       w_checksum;
  logic [31:0]      w_word;
  logic             w_word_valid;

  // Stream is accepted only in the active-load states and never while in reset.
  assign w_ready = !rst && ((r_state == HDR0) || (r_state == HDR1) ||
                            (r_state == PAYLOAD) || (r_state == CHECK));
  assign w_xfer         = byte_valid && w_ready;
  assign w_payload_xfer = w_xfer && (r_state == PAYLOAD);
  assign w_word_end     = w_payload_xfer && (w_lane == 2'd3);
  assign w_last_word    = (r_word_count + CNT_W'(1)) == r_len;
  assign w_len_full     = CNT_W'({byte_data, r_len_lo});

  boot_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (w_payload_xfer),
    .in_data    (byte_data),
    .lane       (w_lane),
    .checksum   (w_checksum),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HDR0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: header length check, word countdown, checksum compare.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HDR0: begin
        if (w_xfer) w_state_next = HDR1;
      end
      HDR1: begin
        if (w_xfer) begin
          if (w_len_full > c_DEPTH)        w_state_next = ERROR;
          else if (w_len_full == '0)       w_state_next = CHECK;
          else                             w_state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (w_word_end && w_last_word) w_state_next = CHECK;
      end
      CHECK: begin
        if (w_xfer) begin
          if (byte_data == w_checksum) w_state_next = DONE;
          else                         w_state_next = ERROR;
        end
      end
      DONE:    w_state_next = DONE;
      ERROR:   w_state_next = ERROR;
      default: w_state_next = ERROR;
    endcase
  end

  // Header length capture: low byte first, full value on the second byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_lo <= 8'd0;
      r_len    <= '0;
    end else if (w_xfer) begin
      if (r_state == HDR0) r_len_lo <= byte_data;
      if (r_state == HDR1) r_len    <= w_len_full;
    end
  end

  // Word address is captured with the completing byte so it lines up with the
  // assembled word; the count steps at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_count <= '0;
      r_waddr      <= 32'd0;
    end else if (w_word_end) begin
      r_word_count <= r_word_count + CNT_W'(1);
      r_waddr      <= word_to_addr(30'(r_word_count));
    end
  end

  // Core reset drops one cycle after the loader settles in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_rst <= 1'b1;
    end else begin
      r_core_rst <= (r_state != DONE);
    end
  end

  assign byte_ready = w_ready;
  assign imem_we    = w_word_valid && !rst;   // a write pending at reset is dropped
  assign imem_waddr = r_waddr;
  assign imem_wdata = w_word;
  assign core_rst   = r_core_rst;
  assign load_done  = (r_state == DONE);
  assign load_err   = (r_state == ERROR);
  assign word_count = r_word_count;

endmodule : imem_boot_loader
`default_nettype wire
